// File: rtl/lcd_psram_sched.sv
// lcd_psram_sched
// Frame scheduler and PSRAM ownership arbiter for the LCD scan-out path.
// It generates the raw LCD timing (hsync/vsync/den, active-high, before any
// output inversion). It issues one line-prefetch request per active line to
// the PSRAM fetch engine. It lends the PSRAM pins to the MCU only inside
// vertical blanking, using a req/ack handshake with bus turnaround.
// Every output is a flop, so a decode of counter position n appears after
// edge n.

module lcd_psram_sched #(
  parameter int H_ACTIVE    = 480,
  parameter int H_FP        = 2,
  parameter int H_SYNC      = 41,
  parameter int H_TOTAL     = 525,
  parameter int V_ACTIVE    = 272,
  parameter int V_FP        = 2,
  parameter int V_SYNC      = 10,
  parameter int V_TOTAL     = 286,
  parameter int TURN_CYCLES = 4
) (
  input  logic       LCD_PCLK,
  input  logic       GLOBAL_RESET,
  input  logic       mcu_req,
  input  logic       fetch_busy,
  input  logic       line_ack,
  output logic       line_req,
  output logic [8:0] line_addr,
  output logic       psram_ctrl,
  output logic       mcu_ack,
  output logic       lcd_hsync,
  output logic       lcd_vsync,
  output logic       lcd_den,
  output logic       frame_start,
  output logic       underrun
);

  // Counter and turnaround widths derived from the timing parameters.
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int TW = $clog2(TURN_CYCLES + 1);

  // Decode thresholds pre-sized to the counter widths.
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYCLES);

  // Ownership FSM encoding.
  localparam logic [2:0] ST_LCD   = 3'd0;  // FPGA owns pins, idle
  localparam logic [2:0] ST_DRAIN = 3'd1;  // waiting for fetch traffic to finish
  localparam logic [2:0] ST_REL   = 3'd2;  // pins released, ack not yet given
  localparam logic [2:0] ST_MCU   = 3'd3;  // MCU granted
  localparam logic [2:0] ST_TURN  = 3'd4;  // bus turnaround before reclaiming

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [VW-1:0] next_line;
  logic          h_wrap;
  logic          v_last;
  logic          win;
  logic          revoke;
  logic          req_meta;
  logic          req_s;
  logic          rearm;
  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [TW-1:0] turn_cnt;

  // Position helpers shared by the decodes, the prefetch and the arbiter.
  assign h_wrap    = (h_cnt == H_LAST);
  assign v_last    = (v_cnt == V_LAST);
  assign next_line = v_last ? '0 : v_cnt + 1'b1;
  // The MCU window is vertical blanking minus the final line, whose slot is
  // used to prefetch line 0 of the next frame.
  assign win       = (v_cnt >= V_ACT) && !v_last;
  assign revoke    = v_last && (h_cnt == '0);

  // Horizontal and vertical pixel position counters.
  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // design samples pre-edge values, independent of block ordering.
  always_ff @(posedge LCD_PCLK or posedge GLOBAL_RESET) begin
    if (GLOBAL_RESET) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Registered raw LCD timing decodes of the current counter position.
  always_ff @(posedge LCD_PCLK or posedge GLOBAL_RESET) begin
    if (GLOBAL_RESET) begin
      lcd_den     <= 1'b0;
      lcd_hsync   <= 1'b0;
      lcd_vsync   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      lcd_den     <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
      lcd_hsync   <= (h_cnt >= HS_BEG) && (h_cnt < HS_END);
      lcd_vsync   <= (v_cnt >= VS_BEG) && (v_cnt < VS_END);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // Line prefetch request: issued at the end of the active part of a line
  // for the next displayed line; an unacknowledged request is dropped at the
  // end of the line and latched as a sticky underrun. An ack on the same
  // edge as the end-of-line check wins, leaving underrun untouched.
  always_ff @(posedge LCD_PCLK or posedge GLOBAL_RESET) begin
    if (GLOBAL_RESET) begin
      line_req  <= 1'b0;
      line_addr <= '0;
      underrun  <= 1'b0;
    end else begin
      if (line_req && line_ack) begin
        line_req <= 1'b0;
      end else if (line_req && h_wrap) begin
        line_req <= 1'b0;
        underrun <= 1'b1;
      end
      if ((h_cnt == H_ACT) && (next_line < V_ACT)) begin
        line_req  <= 1'b1;
        line_addr <= 9'(next_line);
      end
    end
  end

  // Two-flop synchroniser for the asynchronous MCU request.
  always_ff @(posedge LCD_PCLK or posedge GLOBAL_RESET) begin
    if (GLOBAL_RESET) begin
      req_meta <= 1'b0;
      req_s    <= 1'b0;
    end else begin
      req_meta <= mcu_req;
      req_s    <= req_meta;
    end
  end

  // Ownership next-state logic.
  // NOTE: state_nxt takes a default before the case so every path assigns
  // it and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LCD: begin
        if (req_s && rearm && win) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!win)                           state_nxt = ST_LCD;
        else if (!line_req && !fetch_busy)  state_nxt = ST_REL;
      end
      ST_REL: begin
        // A release that lands exactly on the revoke point never grants;
        // otherwise the MCU would hold the pins across the line-0 prefetch.
        state_nxt = revoke ? ST_TURN : ST_MCU;
      end
      ST_MCU: begin
        if (!req_s || revoke) state_nxt = ST_TURN;
      end
      ST_TURN: begin
        if (turn_cnt == '0) state_nxt = ST_LCD;
      end
      default: state_nxt = ST_LCD;
    endcase
  end

  // State register, turnaround counter and registered pin-ownership outputs.
  always_ff @(posedge LCD_PCLK or posedge GLOBAL_RESET) begin
    if (GLOBAL_RESET) begin
      state      <= ST_LCD;
      turn_cnt   <= '0;
      psram_ctrl <= 1'b1;
      mcu_ack    <= 1'b0;
    end else begin
      state      <= state_nxt;
      psram_ctrl <= (state_nxt == ST_LCD) || (state_nxt == ST_DRAIN);
      mcu_ack    <= (state_nxt == ST_MCU);
      if ((state != ST_TURN) && (state_nxt == ST_TURN)) begin
        turn_cnt <= TURN_LOAD;
      end else if ((state == ST_TURN) && (turn_cnt != '0)) begin
        turn_cnt <= turn_cnt - 1'b1;
      end
    end
  end

  // Re-arm flag: a granted MCU must drop its request before the next grant.
  always_ff @(posedge LCD_PCLK or posedge GLOBAL_RESET) begin
    if (GLOBAL_RESET) begin
      rearm <= 1'b1;
    end else if ((state != ST_MCU) && (state_nxt == ST_MCU)) begin
      rearm <= 1'b0;
    end else if (!req_s) begin
      rearm <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_psram_sched.sv
// tb_lcd_psram_sched
// Directed bench for lcd_psram_sched on a 16x8 pixel frame. A table of
// free-running positions checks the timing and prefetch decodes; short
// hand-written sequences cover underrun, MCU grant/release, revoke, delayed
// grant and asynchronous reset during a grant.

module tb_lcd_psram_sched;

  localparam int H_ACTIVE    = 8;
  localparam int H_FP        = 2;
  localparam int H_SYNC      = 2;
  localparam int H_TOTAL     = 16;
  localparam int V_ACTIVE    = 4;
  localparam int V_FP        = 1;
  localparam int V_SYNC      = 1;
  localparam int V_TOTAL     = 8;
  localparam int TURN_CYCLES = 2;

  logic       LCD_PCLK     = 1'b0;
  logic       GLOBAL_RESET = 1'b1;
  logic       mcu_req      = 1'b0;
  logic       fetch_busy   = 1'b0;
  logic       line_ack     = 1'b1;
  logic       line_req;
  logic [8:0] line_addr;
  logic       psram_ctrl;
  logic       mcu_ack;
  logic       lcd_hsync;
  logic       lcd_vsync;
  logic       lcd_den;
  logic       frame_start;
  logic       underrun;

  lcd_psram_sched #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_TOTAL(V_TOTAL),
    .TURN_CYCLES(TURN_CYCLES)
  ) dut (
    .LCD_PCLK    (LCD_PCLK),
    .GLOBAL_RESET(GLOBAL_RESET),
    .mcu_req     (mcu_req),
    .fetch_busy  (fetch_busy),
    .line_ack    (line_ack),
    .line_req    (line_req),
    .line_addr   (line_addr),
    .psram_ctrl  (psram_ctrl),
    .mcu_ack     (mcu_ack),
    .lcd_hsync   (lcd_hsync),
    .lcd_vsync   (lcd_vsync),
    .lcd_den     (lcd_den),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 LCD_PCLK = ~LCD_PCLK;

  int n_tests = 0;
  int n_fail  = 0;
  int edges   = 0;

  // One free-running sample: counter position evaluated, expected decodes.
  typedef struct {
    int         pos;
    logic       den;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       lreq;
    logic [8:0] laddr;
  } vec_t;

  vec_t vt [25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {den,hsync,vsync,frame_start,line_req,line_addr,ctrl,ack,underrun}
  function automatic logic [16:0] pack_out(input logic den, input logic hs, input logic vs,
                                           input logic fs, input logic lreq, input logic [8:0] laddr,
                                           input logic ctrl, input logic ack, input logic urun);
    return {den, hs, vs, fs, lreq, laddr, ctrl, ack, urun};
  endfunction

  function automatic logic [16:0] dut_out();
    return pack_out(lcd_den, lcd_hsync, lcd_vsync, frame_start, line_req, line_addr,
                    psram_ctrl, mcu_ack, underrun);
  endfunction

  // Advance one rising edge; sample and drive 1 time unit after it.
  task automatic tick();
    @(posedge LCD_PCLK);
    #1;
    edges++;
  endtask

  // Advance until n edges have occurred since reset release.
  task automatic goto_edge(input int n);
    while (edges < n) tick();
  endtask

  // Reset with default inputs; release 1 unit after an edge, so edge 1
  // evaluates counter position 0.
  task automatic do_reset();
    mcu_req      = 1'b0;
    fetch_busy   = 1'b0;
    line_ack     = 1'b1;
    GLOBAL_RESET = 1'b1;
    repeat (2) @(posedge LCD_PCLK);
    #1;
    GLOBAL_RESET = 1'b0;
    edges = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // pos, den, hs, vs, fs, lreq, laddr  (ctrl=1, ack=0, underrun=0 throughout)
    vt[0]  = '{0,   1, 0, 0, 1, 0, 9'd0};
    vt[1]  = '{7,   1, 0, 0, 0, 0, 9'd0};
    vt[2]  = '{8,   0, 0, 0, 0, 1, 9'd1};
    vt[3]  = '{9,   0, 0, 0, 0, 0, 9'd1};
    vt[4]  = '{10,  0, 1, 0, 0, 0, 9'd1};
    vt[5]  = '{11,  0, 1, 0, 0, 0, 9'd1};
    vt[6]  = '{12,  0, 0, 0, 0, 0, 9'd1};
    vt[7]  = '{16,  1, 0, 0, 0, 0, 9'd1};
    vt[8]  = '{24,  0, 0, 0, 0, 1, 9'd2};
    vt[9]  = '{25,  0, 0, 0, 0, 0, 9'd2};
    vt[10] = '{40,  0, 0, 0, 0, 1, 9'd3};
    vt[11] = '{55,  1, 0, 0, 0, 0, 9'd3};
    vt[12] = '{56,  0, 0, 0, 0, 0, 9'd3};
    vt[13] = '{64,  0, 0, 0, 0, 0, 9'd3};
    vt[14] = '{74,  0, 1, 0, 0, 0, 9'd3};
    vt[15] = '{79,  0, 0, 0, 0, 0, 9'd3};
    vt[16] = '{80,  0, 0, 1, 0, 0, 9'd3};
    vt[17] = '{95,  0, 0, 1, 0, 0, 9'd3};
    vt[18] = '{96,  0, 0, 0, 0, 0, 9'd3};
    vt[19] = '{104, 0, 0, 0, 0, 0, 9'd3};
    vt[20] = '{120, 0, 0, 0, 0, 1, 9'd0};
    vt[21] = '{121, 0, 0, 0, 0, 0, 9'd0};
    vt[22] = '{128, 1, 0, 0, 1, 0, 9'd0};
    vt[23] = '{129, 1, 0, 0, 0, 0, 9'd0};
    vt[24] = '{136, 0, 0, 0, 0, 1, 9'd1};

    // Reset values, then the free-running table with line_ack tied high.
    do_reset();
    check("reset_state", 32'(dut_out()), 32'(pack_out(0, 0, 0, 0, 0, 9'd0, 1, 0, 0)));
    for (int i = 0; i < 25; i++) begin
      goto_edge(vt[i].pos + 1);
      check($sformatf("free v%0d h%0d", (vt[i].pos / H_TOTAL) % V_TOTAL, vt[i].pos % H_TOTAL),
            32'(dut_out()),
            32'(pack_out(vt[i].den, vt[i].hs, vt[i].vs, vt[i].fs, vt[i].lreq, vt[i].laddr, 1, 0, 0)));
    end

    // line_ack held low: request survives the line, then underrun latches.
    do_reset();
    line_ack = 1'b0;
    goto_edge(9);
    check("nack_req_rise", 32'({line_req, line_addr}), 32'({1'b1, 9'd1}));
    goto_edge(15);
    check("nack_req_held_h14", 32'({line_req, underrun}), 32'(2'b10));
    goto_edge(16);
    check("nack_req_drop_h15", 32'({line_req, underrun}), 32'(2'b01));
    line_ack = 1'b1;
    goto_edge(25);
    check("nack_next_req", 32'({line_req, line_addr, underrun}), 32'({1'b1, 9'd2, 1'b1}));
    goto_edge(26);
    check("nack_next_acked", 32'({line_req, underrun}), 32'(2'b01));
    goto_edge(60);
    check("underrun_sticky", 32'(underrun), 32'(1));

    // Ack arriving on the same edge as the end-of-line check wins.
    do_reset();
    line_ack = 1'b0;
    goto_edge(15);
    line_ack = 1'b1;
    goto_edge(16);
    check("late_ack_no_underrun", 32'({line_req, underrun}), 32'(2'b00));

    // Request in blanking: ack 5 edges later, release 3 cycles after drop.
    do_reset();
    goto_edge(64);
    mcu_req = 1'b1;
    goto_edge(67);
    check("grant_drain", 32'({psram_ctrl, mcu_ack}), 32'(2'b10));
    goto_edge(68);
    check("grant_rel", 32'({psram_ctrl, mcu_ack}), 32'(2'b00));
    goto_edge(69);
    check("grant_ack", 32'({psram_ctrl, mcu_ack}), 32'(2'b01));
    goto_edge(72);
    mcu_req = 1'b0;
    goto_edge(74);
    check("drop_ack_still", 32'(mcu_ack), 32'(1));
    goto_edge(75);
    check("drop_ack_fall", 32'({psram_ctrl, mcu_ack}), 32'(2'b00));
    goto_edge(77);
    check("turn_ctrl_low", 32'(psram_ctrl), 32'(0));
    goto_edge(78);
    check("turn_ctrl_back", 32'({psram_ctrl, mcu_ack}), 32'(2'b10));
    goto_edge(100);
    check("no_regrant_idle", 32'({psram_ctrl, mcu_ack}), 32'(2'b10));

    // Request held through the revoke point.
    do_reset();
    goto_edge(64);
    mcu_req = 1'b1;
    goto_edge(112);
    check("hold_ack_before_revoke", 32'(mcu_ack), 32'(1));
    goto_edge(113);
    check("revoke_ack_fall", 32'({psram_ctrl, mcu_ack}), 32'(2'b00));
    goto_edge(115);
    check("revoke_turn", 32'(psram_ctrl), 32'(0));
    goto_edge(116);
    check("revoke_ctrl_back_h3", 32'(psram_ctrl), 32'(1));
    goto_edge(121);
    check("revoke_line0_req", 32'({line_req, line_addr, psram_ctrl}), 32'({1'b1, 9'd0, 1'b1}));
    goto_edge(200);
    check("revoke_no_regrant", 32'({psram_ctrl, mcu_ack}), 32'(2'b10));
    mcu_req = 1'b0;
    goto_edge(204);
    mcu_req = 1'b1;
    goto_edge(208);
    check("rearm_rel", 32'({psram_ctrl, mcu_ack}), 32'(2'b00));
    goto_edge(209);
    check("rearm_grant", 32'(mcu_ack), 32'(1));

    // Request during active video, grant held off by fetch_busy.
    do_reset();
    goto_edge(32);
    mcu_req = 1'b1;
    goto_edge(60);
    fetch_busy = 1'b1;
    goto_edge(64);
    check("active_no_ack", 32'({psram_ctrl, mcu_ack}), 32'(2'b10));
    goto_edge(72);
    check("busy_no_ack", 32'({psram_ctrl, mcu_ack}), 32'(2'b10));
    fetch_busy = 1'b0;
    goto_edge(73);
    check("busy_release", 32'({psram_ctrl, mcu_ack}), 32'(2'b00));
    goto_edge(74);
    check("busy_grant", 32'({psram_ctrl, mcu_ack}), 32'(2'b01));

    // Asynchronous reset in the middle of a grant.
    do_reset();
    goto_edge(64);
    mcu_req = 1'b1;
    goto_edge(70);
    check("pre_reset_ack", 32'(mcu_ack), 32'(1));
    #2;
    GLOBAL_RESET = 1'b1;
    #1;
    check("async_reset_outputs", 32'(dut_out()), 32'(pack_out(0, 0, 0, 0, 0, 9'd0, 1, 0, 0)));
    do_reset();
    tick();
    check("post_reset_first", 32'({lcd_den, frame_start, psram_ctrl, mcu_ack}), 32'(4'b1110));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
